// File: rtl/scale_addr_pipe.sv
// scale_addr_pipe: maps VGA scan coordinates to source-image coordinates.
// Zoom-in (>>k), zoom-out (<<k) or identity, then pan offset and bounds check,
// through a valid/ready pipeline. Configuration is shadowed at frame_start.
// Optional: define LINEAR_ADDR_EN to add a third stage that produces the
// linear frame-buffer address (latency 3 instead of 2).
`timescale 1ns/1ps

module scale_addr_pipe #(
    parameter int unsigned WIDTH_IN  = 160,
    parameter int unsigned HEIGHT_IN = 120,
    parameter int unsigned VGA_W     = 10,
    parameter int unsigned MAX_K     = 3,
    parameter int unsigned XW        = $clog2(WIDTH_IN),
    parameter int unsigned YW        = $clog2(HEIGHT_IN)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             frame_start,
    input  logic [1:0]       cfg_mode,
    input  logic [1:0]       cfg_k,
    input  logic [XW-1:0]    cfg_pan_x,
    input  logic [YW-1:0]    cfg_pan_y,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [VGA_W-1:0] x_vga,
    input  logic [VGA_W-1:0] y_vga,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XW-1:0]    x_img,
    output logic [YW-1:0]    y_img,
`ifdef LINEAR_ADDR_EN
    output logic [$clog2(WIDTH_IN*HEIGHT_IN)-1:0] addr,
`endif
    output logic             in_bounds
);

    // Scaled coordinates need MAX_K extra bits so zoom-out never truncates;
    // one more bit holds the pan sum.
    localparam int unsigned SW = VGA_W + MAX_K;
    localparam int unsigned PW = SW + 1;
    localparam logic [PW-1:0] X_LIM = PW'(WIDTH_IN);
    localparam logic [PW-1:0] Y_LIM = PW'(HEIGHT_IN);
    localparam logic [1:0]    K_MAX = 2'(MAX_K);

    // Shadow configuration
    logic [1:0]    sh_mode, sh_k;
    logic [XW-1:0] sh_pan_x;
    logic [YW-1:0] sh_pan_y;

    // Configuration seen by a coordinate accepted this cycle
    logic [1:0]    cfg_k_sat;
    logic [1:0]    acc_mode, acc_k;
    logic [XW-1:0] acc_pan_x;
    logic [YW-1:0] acc_pan_y;

    // Stage 1 registers and next values
    logic          s1_valid;
    logic [SW-1:0] s1_sx, s1_sy;
    logic [XW-1:0] s1_pan_x;
    logic [YW-1:0] s1_pan_y;
    logic [SW-1:0] x_ext, y_ext, sx, sy;

    // Stage 2 registers and next values
    logic          s2_valid;
    logic [XW-1:0] s2_x;
    logic [YW-1:0] s2_y;
    logic          s2_inb;
    logic [PW-1:0] px, py;
    logic          inb_next;
    logic [XW-1:0] x_next;
    logic [YW-1:0] y_next;

    logic s1_load, s2_load;

`ifdef LINEAR_ADDR_EN
    localparam int unsigned AW = $clog2(WIDTH_IN * HEIGHT_IN);
    localparam logic [AW-1:0] ADDR_STRIDE = AW'(WIDTH_IN);

    logic          s3_valid;
    logic [XW-1:0] s3_x;
    logic [YW-1:0] s3_y;
    logic          s3_inb;
    logic [AW-1:0] s3_addr;
    logic [AW-1:0] addr_next;
    logic          s3_load;
`endif

    // Stage loads: a stage takes new data when empty or when its successor moves on
    always_comb begin
`ifdef LINEAR_ADDR_EN
        s3_load = !s3_valid || out_ready;
        s2_load = !s2_valid || s3_load;
`else
        s2_load = !s2_valid || out_ready;
`endif
        s1_load  = !s1_valid || s2_load;
        in_ready = s1_load;
    end

    // A frame_start in the accept cycle applies its new config to that coordinate
    always_comb begin
        cfg_k_sat = (32'(cfg_k) > MAX_K) ? K_MAX : cfg_k;
        if (frame_start) begin
            acc_mode  = cfg_mode;
            acc_k     = cfg_k_sat;
            acc_pan_x = cfg_pan_x;
            acc_pan_y = cfg_pan_y;
        end else begin
            acc_mode  = sh_mode;
            acc_k     = sh_k;
            acc_pan_x = sh_pan_x;
            acc_pan_y = sh_pan_y;
        end
    end

    // Shadow config register; reset state is identity with no pan
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sh_mode  <= 2'd2;
            sh_k     <= 2'd0;
            sh_pan_x <= '0;
            sh_pan_y <= '0;
        end else if (frame_start) begin
            sh_mode  <= cfg_mode;
            sh_k     <= cfg_k_sat;
            sh_pan_x <= cfg_pan_x;
            sh_pan_y <= cfg_pan_y;
        end
    end

    // Stage 1 scale; modes 2 and 3 are both identity
    always_comb begin
        x_ext = SW'(x_vga);
        y_ext = SW'(y_vga);
        case (acc_mode)
            2'd0: begin
                sx = x_ext >> acc_k;
                sy = y_ext >> acc_k;
            end
            2'd1: begin
                sx = x_ext << acc_k;
                sy = y_ext << acc_k;
            end
            default: begin
                sx = x_ext;
                sy = y_ext;
            end
        endcase
    end

    // Stage 1 register; pan travels with the data so later config changes don't affect it
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            s1_valid <= 1'b0;
            s1_sx    <= '0;
            s1_sy    <= '0;
            s1_pan_x <= '0;
            s1_pan_y <= '0;
        end else if (s1_load) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_sx    <= sx;
                s1_sy    <= sy;
                s1_pan_x <= acc_pan_x;
                s1_pan_y <= acc_pan_y;
            end
        end
    end

    // Stage 2 pan and bounds; out-of-range coordinates are forced to zero, never wrapped
    always_comb begin
        px       = PW'(s1_sx) + PW'(s1_pan_x);
        py       = PW'(s1_sy) + PW'(s1_pan_y);
        inb_next = (px < X_LIM) && (py < Y_LIM);
        x_next   = inb_next ? px[XW-1:0] : '0;
        y_next   = inb_next ? py[YW-1:0] : '0;
    end

    // Stage 2 register
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            s2_valid <= 1'b0;
            s2_x     <= '0;
            s2_y     <= '0;
            s2_inb   <= 1'b0;
        end else if (s2_load) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_x   <= x_next;
                s2_y   <= y_next;
                s2_inb <= inb_next;
            end
        end
    end

`ifdef LINEAR_ADDR_EN
    // Stage 3 linear address; x/y are already zero when out of bounds
    always_comb begin
        addr_next = s2_inb ? (AW'(s2_y) * ADDR_STRIDE + AW'(s2_x)) : '0;
    end

    // Stage 3 register
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            s3_valid <= 1'b0;
            s3_x     <= '0;
            s3_y     <= '0;
            s3_inb   <= 1'b0;
            s3_addr  <= '0;
        end else if (s3_load) begin
            s3_valid <= s2_valid;
            if (s2_valid) begin
                s3_x    <= s2_x;
                s3_y    <= s2_y;
                s3_inb  <= s2_inb;
                s3_addr <= addr_next;
            end
        end
    end

    assign out_valid = s3_valid;
    assign x_img     = s3_x;
    assign y_img     = s3_y;
    assign in_bounds = s3_inb;
    assign addr      = s3_addr;
`else
    assign out_valid = s2_valid;
    assign x_img     = s2_x;
    assign y_img     = s2_y;
    assign in_bounds = s2_inb;
`endif

endmodule

// File: doc/scale_addr_pipe.md
Name: scale_addr_pipe

Overview:
- Parametrised successor to the single-mode zoom coordinate mapper.
- Maps VGA scan coordinates to source-image coordinates for zoom-in (÷2^k), zoom-out (×2^k) and identity.
- Adds pan offsets, in-bounds flagging and a 2-stage valid/ready pipeline.
- Configuration is shadowed and applied only at frame start, so scale and pan changes never tear mid-frame.
- Sits between the VGA timing generator and the frame-buffer read port.

Parameters:
- WIDTH_IN, 160: source image width in pixels.
- HEIGHT_IN, 120: source image height in pixels.
- VGA_W, 10: width of the VGA coordinate inputs.
- MAX_K, 3: largest allowed scale exponent; cfg_k above this saturates to MAX_K.
- XW, $clog2(WIDTH_IN): width of x_img and cfg_pan_x.
- YW, $clog2(HEIGHT_IN): width of y_img and cfg_pan_y.

Ports:
- clk, in, 1: system clock, 100 MHz.
- reset_n, in, 1: synchronous active-low reset, sampled on the rising edge of clk.
- frame_start, in, 1: single-cycle pulse; loads the cfg_* inputs into the shadow registers.
- cfg_mode, in, 2: 0 = zoom-in, 1 = zoom-out, 2 = identity, 3 = identity.
- cfg_k, in, 2: scale exponent.
- cfg_pan_x, in, XW: x offset in source pixels.
- cfg_pan_y, in, YW: y offset in source pixels.
- in_valid, in, 1: x_vga/y_vga carry a valid coordinate.
- in_ready, out, 1: pipeline can accept an input this cycle.
- x_vga, in, VGA_W: VGA column.
- y_vga, in, VGA_W: VGA row.
- out_valid, out, 1: output holds a valid mapped coordinate.
- out_ready, in, 1: downstream accepts the output this cycle.
- x_img, out, XW: mapped source column.
- y_img, out, YW: mapped source row.
- in_bounds, out, 1: mapped coordinate lies inside the source image.
- addr, out, $clog2(WIDTH_IN*HEIGHT_IN): linear address; present only when LINEAR_ADDR_EN is defined.

Behaviour:
- Reset (reset_n=0 at a clk edge):
  - out_valid=0, x_img=0, y_img=0, in_bounds=0, addr=0.
  - Both stage valids are cleared.
  - Shadow config becomes mode=2, k=0, pan_x=0, pan_y=0.
  - Reset mid-stream discards any in-flight data; no output is produced for it.
- Shadow config:
  - Updated from cfg_* on any clk edge where frame_start=1 and reset_n=1.
  - A coordinate accepted in that same cycle uses the NEW config.
  - cfg_k is saturated to MAX_K before storage.
- Handshake:
  - Input is accepted when in_valid && in_ready.
  - Output is transferred when out_valid && out_ready.
  - Each stage loads when its own valid is 0 or the next stage is loading or draining.
  - in_ready = !s1_valid || (!s2_valid || out_ready).
  - Full throughput is 1 coordinate/cycle; there are no bubbles while out_ready=1.
  - With out_ready=0, both stages fill, then in_ready=0. Outputs hold stable until accepted; no data is lost or duplicated.
- Stage 1, scale (mode taken from the shadow config):
  - Zoom-in: sx = x_vga >> k, sy = y_vga >> k.
  - Zoom-out: sx = x_vga << k, sy = y_vga << k, computed at VGA_W+MAX_K bits with no truncation.
  - Identity: sx = x_vga, sy = y_vga.
- Stage 2, pan and bounds:
  - px = sx + pan_x, computed at VGA_W+MAX_K+1 bits; py likewise.
  - in_bounds = (px < WIDTH_IN) && (py < HEIGHT_IN).
  - If in_bounds: x_img = px[XW-1:0], y_img = py[YW-1:0].
  - If not in_bounds: x_img=0, y_img=0. There is no wrap-around.
- Latency:
  - Exactly 2 cycles from input accept to out_valid when out_ready stays 1.
  - Config captured at accept time travels with the data, so a frame_start during a stall does not alter in-flight pixels.
- Boundary conditions:
  - x_vga=1023 in zoom-out with k=3 gives 8184; this sets in_bounds=0 with no overflow.
  - frame_start together with a stall: config is still loaded; in-flight data is unaffected.
  - cfg_mode=3 behaves exactly as identity.

Optional Feature:
- Macro: LINEAR_ADDR_EN.
- Defined:
  - An extra pipeline stage computes addr = y_img*WIDTH_IN + x_img, registered with the data.
  - Latency becomes 3 cycles; addr=0 when in_bounds=0.
  - The handshake rules extend to 3 stages.
- Undefined:
  - addr port is absent; latency is 2 cycles.

Test Plan:
- Reset then idle, check outputs: out_valid=0, in_ready=1, x_img=y_img=0, in_bounds=0.
- frame_start with mode=0, k=2, pan=(0,0); stream (100,50) with out_ready=1 -> 2 cycles later x_img=25, y_img=12, in_bounds=1.
- Mode=1, k=1, pan=(10,5):
  - Input (70,40) -> x_img=150, y_img=85, in_bounds=1.
  - Input (80,40) -> px=170, so in_bounds=0 and x_img=y_img=0.
- cfg_k=3 with MAX_K=2, mode=0, input (8,8) -> x_img=2, y_img=2, confirming saturation to k=2.
- Back-pressure: stream 4 coordinates, hold out_ready=0 for 5 cycles, then release -> in_ready=0 after 2 accepts; all 4 outputs arrive in order, unchanged, none duplicated.
- Mid-frame config change: change cfg_* without frame_start -> mapping unchanged. Pulse frame_start while the pipeline is stalled -> in-flight pixels keep the old mapping. Apply reset_n=0 for 1 cycle mid-stream -> out_valid=0 next cycle and shadow config returns to identity.
